// File: rtl/alu_pkg.sv
// Shared types for the EX-stage integer ALU.
// Pure declarations, no logic; no latency or backpressure of its own.
// Operation codes not listed in alu_op_t are reserved and produce a zero result.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } alu_flags_t;

endpackage

// File: rtl/alu64_if.sv
// Operand/result bundle between the issue logic and the ALU.
// Combinational wiring only; no handshake, so there is no backpressure.
// cntrl stays a raw 3-bit field so that reserved codes can be carried.
interface alu64_if import alu_pkg::*; #(parameter int WIDTH = ALU_WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output A, B, cntrl,
    input  result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  A, B, cntrl,
    output result, negative, zero, overflow, carry_out
  );

endinterface

// File: rtl/alu_adder.sv
// WIDTH-bit ripple-carry adder returning the sum, carry out and carry into the MSB.
// Purely combinational, zero cycles.
// No handshake and never stalls.
module alu_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic carry;

  // Carry is kept as a loop variable rather than a vector so the chain stays one combinational block.
  always_comb begin
    carry    = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        c_msb_in = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/alu64.sv
// 64-bit EX-stage ALU: pass-B, add, sub, and, or, xor with NZVC flags.
// One cycle latency: outputs reflect the operands sampled at the previous edge.
// No handshake or stall; a new operation is accepted every cycle.
module alu64 import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  alu64_if.slave bus
);

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             c_msb_in;
  logic [WIDTH-1:0] result_nxt;
  alu_flags_t       flags_nxt;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;

  assign is_sub   = (bus.cntrl == ALU_SUBTRACT);
  assign is_arith = (bus.cntrl == ALU_ADD) || is_sub;
  assign b_opnd   = is_sub ? ~bus.B : bus.B;

  // Subtract reuses the adder as A + ~B + 1, giving ARM-style carry (1 = no borrow).
  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (bus.A),
    .b        (b_opnd),
    .cin      (is_sub),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );

  always_comb begin
    result_nxt = '0;
    case (bus.cntrl)
      ALU_PASS_B:             result_nxt = bus.B;
      ALU_ADD, ALU_SUBTRACT:  result_nxt = sum;
      ALU_AND:                result_nxt = bus.A & bus.B;
      ALU_OR:                 result_nxt = bus.A | bus.B;
      ALU_XOR:                result_nxt = bus.A ^ bus.B;
      default:                result_nxt = '0;
    endcase
    flags_nxt.negative  = result_nxt[WIDTH-1];
    flags_nxt.zero      = (result_nxt == '0);
    flags_nxt.overflow  = is_arith & (c_msb_in ^ cout);
    flags_nxt.carry_out = is_arith & cout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '{negative: 1'b0, zero: 1'b1, overflow: 1'b0, carry_out: 1'b0};
    end else begin
      result_q <= result_nxt;
      flags_q  <= flags_nxt;
    end
  end

  assign bus.result    = result_q;
  assign bus.negative  = flags_q.negative;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;
  assign bus.carry_out = flags_q.carry_out;

endmodule

// File: tb/tb_alu64.sv
// Bench for alu64: directed vector table, random ops against a plain-arithmetic model,
// back-to-back op changes and reset sequences.
module tb_alu64;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu64_if #(.WIDTH(ALU_WIDTH)) bus ();

  alu64 #(.WIDTH(ALU_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                              input logic [63:0] r, input logic n, input logic z,
                              input logic v, input logic c);
    vec_t t;
    t.a = a; t.b = b; t.op = op; t.r = r; t.n = n; t.z = z; t.v = v; t.c = c;
    return t;
  endfunction

  // Reference: unsigned/signed arithmetic rules, no adder model.
  function automatic vec_t model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
    vec_t        e;
    logic [64:0] w;
    e.a = a; e.b = b; e.op = op; e.v = 1'b0; e.c = 1'b0;
    case (op)
      3'b000: e.r = b;
      3'b010: begin
        w   = {1'b0, a} + {1'b0, b};
        e.r = w[63:0];
        e.c = w[64];
        e.v = (a[63] == b[63]) && (e.r[63] != a[63]);
      end
      3'b011: begin
        e.r = a - b;
        e.c = (a >= b);
        e.v = (a[63] != b[63]) && (e.r[63] != a[63]);
      end
      3'b100:  e.r = a & b;
      3'b101:  e.r = a | b;
      3'b110:  e.r = a ^ b;
      default: e.r = 64'd0;
    endcase
    e.n = e.r[63];
    e.z = (e.r == 64'd0);
    return e;
  endfunction

  task automatic check(input string nm, input vec_t e);
    checks++;
    if ({bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out} !== {e.r, e.n, e.z, e.v, e.c}) begin
      failures++;
      $display("FAIL %s: got r=%h nzvc=%b%b%b%b required r=%h nzvc=%b%b%b%b (A=%h B=%h op=%b)",
               nm, bus.result, bus.negative, bus.zero, bus.overflow, bus.carry_out,
               e.r, e.n, e.z, e.v, e.c, e.a, e.b, e.op);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.A     = t.a;
    bus.B     = t.b;
    bus.cntrl = t.op;
  endtask

  task automatic run_one(input string nm, input vec_t t);
    @(negedge clk);
    drive(t);
    @(posedge clk);
    #1;
    check(nm, t);
  endtask

  vec_t tbl[17];
  vec_t rst_exp;
  vec_t q[$];
  vec_t t;
  logic [2:0] ops[8];
  logic [2:0] b2b_ops[5];

  initial begin
    rst_exp = mk(64'd0, 64'd0, 3'b000, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    ops     = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b111};
    b2b_ops = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b111};

    tbl[0]  = mk(64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0);
    tbl[1]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 1, 0, 1, 0);
    tbl[2]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 0, 1, 0, 1);
    tbl[3]  = mk(64'd5, 64'd3, 3'b011, 64'd2, 0, 0, 0, 1);
    tbl[4]  = mk(64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
    tbl[5]  = mk(64'h8000_0000_0000_0000, 64'd1, 3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
    tbl[6]  = mk(64'd0, 64'd0, 3'b011, 64'd0, 0, 1, 0, 1);
    tbl[7]  = mk(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b100, 64'hF000_F000_F000_F000, 1, 0, 0, 0);
    tbl[8]  = mk(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b101, 64'hFFF0_FFF0_FFF0_FFF0, 1, 0, 0, 0);
    tbl[9]  = mk(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'b110, 64'h0FF0_0FF0_0FF0_0FF0, 0, 0, 0, 0);
    tbl[10] = mk(64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 3'b110, 64'd0, 0, 1, 0, 0);
    tbl[11] = mk(64'h1234_5678_9ABC_DEF0, 64'd0, 3'b000, 64'd0, 0, 1, 0, 0);
    tbl[12] = mk(64'd7, 64'h8000_0000_0000_0000, 3'b000, 64'h8000_0000_0000_0000, 1, 0, 0, 0);
    tbl[13] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b001, 64'd0, 0, 1, 0, 0);
    tbl[14] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'd0, 0, 1, 0, 0);
    tbl[15] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010, 64'd0, 0, 1, 1, 1);
    tbl[16] = mk(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 3'b011, 64'h8000_0000_0000_0001, 1, 0, 1, 0);

    // Reset held for two edges with arbitrary operands.
    rst_n = 1'b0;
    drive(mk({$urandom, $urandom}, {$urandom, $urandom}, 3'b010, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", rst_exp);
    end
    @(negedge clk);
    drive(mk(64'd1, 64'd1, 3'b010, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    check("reset_release_still_reset", rst_exp);
    @(posedge clk);
    #1;
    check("first_after_release", mk(64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0));

    for (int i = 0; i < 17; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i]);
    end

    // Pass-B with random operands, plus every op against the model.
    for (int i = 0; i < 100; i++) begin
      run_one("pass_b_rand", model({$urandom, $urandom}, {$urandom, $urandom}, 3'b000));
    end
    for (int i = 0; i < 300; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) ra[63:1] = {63{ra[0]}};
      run_one("rand_op", model(ra, rb, ops[$urandom_range(0, 7)]));
    end

    // Back-to-back op changes: each output reflects the previous edge's inputs.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        t = q.pop_front();
        check("back_to_back", t);
      end
      if (k < 5) begin
        t = model({$urandom, $urandom}, {$urandom, $urandom}, b2b_ops[k]);
        drive(t);
        q.push_back(t);
      end
    end

    // Reset asserted mid-stream wins over a valid op at the same edge.
    @(negedge clk);
    drive(mk(64'd1, 64'd1, 3'b010, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midstream_reset", rst_exp);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midstream_release_still_reset", rst_exp);
    @(posedge clk);
    #1;
    check("midstream_first_result", mk(64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu64.md
Name: alu64

Overview:
- 64-bit integer ALU for the ARM core datapath (EX stage).
- Supports pass-B, add, subtract, AND, OR and XOR, selected by a 3-bit control code.
- Produces the result plus negative, zero, overflow and carry flags.
- Result and flags are registered: one-cycle latency from inputs to outputs.

Parameters:
- WIDTH, 64, datapath width; flags always refer to bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  operation select.
- result  output  WIDTH  registered operation result.
- negative  output  1  registered; result[WIDTH-1].
- zero  output  1  registered; 1 when result is all zeros.
- overflow  output  1  registered; signed overflow on add/sub.
- carry_out  output  1  registered; carry out of the MSB on add/sub.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low. While rst_n=0 at a rising edge, outputs take these values:
  - result = 0
  - negative = 0
  - zero = 1 (consistent with a zero result)
  - overflow = 0
  - carry_out = 0
- Latency: every rising edge with rst_n=1 captures f(A, B, cntrl) into the output registers, so outputs reflect the inputs sampled at the previous edge. There is no handshake and no stall. A new operation can be issued every cycle.
- Operations by cntrl:
  - 000: result = B.
  - 010: result = A + B (mod 2^WIDTH).
  - 011: result = A - B, computed as A + ~B + 1 on the shared adder.
  - 100: result = A & B.
  - 101: result = A | B.
  - 110: result = A ^ B.
  - 001 and 111 (reserved): result = 0.
- negative = result[WIDTH-1] for every operation.
- zero = (result == 0) for every operation.
- Add/sub flags:
  - carry_out = carry out of bit WIDTH-1 of the adder. For subtract this is ARM-style: 1 means no borrow (A >= B unsigned).
  - overflow = carry into MSB XOR carry out of MSB (signed overflow).
- All non-add/sub codes, including reserved ones: overflow = 0 and carry_out = 0.
- Boundary cases:
  - 0 - 0: result 0, zero=1, carry_out=1, overflow=0.
  - Add wrap-around: FFFF_FFFF_FFFF_FFFF + 1 gives result 0, zero=1, carry_out=1, overflow=0.
- Reset asserted mid-stream: the reset values win at that edge. The first valid result appears one edge after rst_n rises.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t (3-bit enum): ALU_PASS_B=000, ALU_ADD=010, ALU_SUBTRACT=011, ALU_AND=100, ALU_OR=101, ALU_XOR=110.
  - Constant ALU_WIDTH=64.
- One sub-module, alu_adder: WIDTH-bit adder taking a, b and cin. It returns sum, cout and c_msb_in (carry into the MSB) for overflow.
  - Built as a ripple of full-adder cells or 4-bit lookahead groups.
  - Subtract feeds ~B with cin=1.
- The top level does operand inversion, the logic ops, the result mux, flag generation and the output register.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with arbitrary inputs -> result=0, zero=1, negative=0, overflow=0, carry_out=0. Release; the first result appears one edge later.
- Pass-B: cntrl=000 with 100 random A/B pairs, including B=0 and B=8000_0000_0000_0000 -> result==B, negative==B[63], zero==(B==0), overflow=0, carry_out=0, each one cycle after apply.
- Add: 1+1 -> 2, all flags 0. 7FFF_FFFF_FFFF_FFFF+1 -> 8000_0000_0000_0000, overflow=1, negative=1, carry_out=0. FFFF_FFFF_FFFF_FFFF+1 -> 0, zero=1, carry_out=1, overflow=0.
- Subtract: 5-3 -> 2, carry_out=1. 3-5 -> FFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0. 8000_0000_0000_0000-1 -> 7FFF_FFFF_FFFF_FFFF, overflow=1, carry_out=1. 0-0 -> 0, zero=1, carry_out=1.
- Logic: A=F0F0_F0F0_F0F0_F0F0, B=FF00_FF00_FF00_FF00 ->
  - AND = F000_F000_F000_F000
  - OR = FFF0_FFF0_FFF0_FFF0
  - XOR = 0FF0_0FF0_0FF0_0FF0
  - overflow=carry_out=0 throughout; XOR of A with itself -> zero=1.
- Back-to-back and reserved codes: change cntrl every cycle (ADD, SUB, AND, 001, 111) -> each output matches the op from the previous edge. Reserved codes give result=0, zero=1, overflow=carry_out=0.
